// File: rtl/lfsr_err_inject_gen.sv
// lfsr_err_inject_gen
// XNOR-Fibonacci LFSR pseudo-random source for the error-insertion datapath.
// The state advances by STEPS shifts per enabled clock. The all-ones XNOR
// lock-up state is detected and recovered to zero. A threshold comparator on
// the low state bits produces a per-step error-fire pulse. Saturating
// counters track fired errors and lock-up recoveries.
module lfsr_err_inject_gen #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = 32'h80200003,
    parameter int               STEPS    = 1,
    parameter int               THRESH_W = 16,
    parameter int               CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                cnt_clr,
    output logic [WIDTH-1:0]    random_number,
    output logic                err_fire,
    output logic [CNT_W-1:0]    err_count,
    output logic                lockup,
    output logic [CNT_W-1:0]    lockup_count
);

    // Reject configurations the datapath cannot honour.
    if (WIDTH < 8) begin : g_bad_width
        $error("lfsr_err_inject_gen: WIDTH must be at least 8");
    end
    if ((STEPS < 1) || (STEPS > WIDTH)) begin : g_bad_steps
        $error("lfsr_err_inject_gen: STEPS must lie in 1..WIDTH");
    end
    if (THRESH_W > WIDTH) begin : g_bad_thresh
        $error("lfsr_err_inject_gen: THRESH_W must not exceed WIDTH");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_err_inject_gen: TAPS must not be zero");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // One XNOR-Fibonacci shift: feedback is the inverted parity of tapped bits.
    function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ~(^(s & TAPS));
        return {s[WIDTH-2:0], fb};
    endfunction

    logic [WIDTH-1:0] state_r;
    logic             err_fire_r;
    logic [CNT_W-1:0] err_count_r;
    logic [CNT_W-1:0] lockup_count_r;

    logic [WIDTH-1:0] step_s;
    logic             fire_s;
    logic             lockup_s;
    logic             err_inc_s;
    logic             lock_inc_s;

    // Chain STEPS single shifts and evaluate the comparator on the stepped state.
    always_comb begin
        step_s = state_r;
        for (int i = 0; i < STEPS; i++) begin
            step_s = lfsr_shift(step_s);
        end
        fire_s = (step_s[THRESH_W-1:0] < threshold);
    end

    // Decode lock-up and which counter (if any) steps on this edge.
    always_comb begin
        lockup_s   = &state_r;
        err_inc_s  = 1'b0;
        lock_inc_s = 1'b0;
        if (!load && clk_en) begin
            if (lockup_s) begin
                lock_inc_s = 1'b1;
            end else begin
                err_inc_s = fire_s;
            end
        end else begin
            err_inc_s  = 1'b0;
            lock_inc_s = 1'b0;
        end
    end

    // State register and fire pulse: reset > load > step/recover > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= '0;
            err_fire_r <= 1'b0;
        end else begin
            err_fire_r <= 1'b0;
            if (load) begin
                state_r <= seed_in;
            end else if (clk_en) begin
                if (lockup_s) begin
                    state_r <= '0;
                end else begin
                    state_r    <= step_s;
                    err_fire_r <= fire_s;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Saturating counters; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r    <= '0;
            lockup_count_r <= '0;
        end else if (cnt_clr) begin
            err_count_r    <= '0;
            lockup_count_r <= '0;
        end else begin
            if (err_inc_s && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_ONE;
            end else begin
                err_count_r <= err_count_r;
            end
            if (lock_inc_s && (lockup_count_r != CNT_MAX)) begin
                lockup_count_r <= lockup_count_r + CNT_ONE;
            end else begin
                lockup_count_r <= lockup_count_r;
            end
        end
    end

    assign random_number = state_r;
    assign err_fire      = err_fire_r;
    assign err_count     = err_count_r;
    assign lockup        = lockup_s;
    assign lockup_count  = lockup_count_r;

endmodule

// File: tb/tb_lfsr_err_inject_gen.sv
// Testbench for lfsr_err_inject_gen: directed vector table, hand-written
// multi-cycle sequences on STEPS=4 and narrow-counter instances, and
// randomized stimulus against a behavioural reference model.
module tb_lfsr_err_inject_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults)
    logic        rst, clk_en, load, cnt_clr;
    logic [31:0] seed_in;
    logic [15:0] threshold;
    logic [31:0] random_number;
    logic        err_fire, lockup;
    logic [15:0] err_count, lockup_count;

    // Shared stimulus for the secondary instances
    logic        rst2, en2, load2, clr2;
    logic [31:0] seed2;
    logic [15:0] thr2;

    logic [31:0] rn4;
    logic        fire4, lk4;
    logic [15:0] ec4, lc4;

    logic [31:0] rns;
    logic        fires, lks;
    logic [3:0]  ecs, lcs;

    lfsr_err_inject_gen u_dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .load(load), .seed_in(seed_in),
        .threshold(threshold), .cnt_clr(cnt_clr), .random_number(random_number),
        .err_fire(err_fire), .err_count(err_count), .lockup(lockup),
        .lockup_count(lockup_count)
    );

    lfsr_err_inject_gen #(.STEPS(4)) u_dut4 (
        .clk(clk), .rst(rst2), .clk_en(en2), .load(load2), .seed_in(seed2),
        .threshold(thr2), .cnt_clr(clr2), .random_number(rn4),
        .err_fire(fire4), .err_count(ec4), .lockup(lk4), .lockup_count(lc4)
    );

    lfsr_err_inject_gen #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst2), .clk_en(en2), .load(load2), .seed_in(seed2),
        .threshold(thr2), .cnt_clr(clr2), .random_number(rns),
        .err_fire(fires), .err_count(ecs), .lockup(lks), .lockup_count(lcs)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference shift: double the value, append 1 when an even number of taps are set.
    function automatic logic [31:0] ref_shift(input logic [31:0] s);
        int          ones;
        logic [31:0] r;
        ones = $countones(s & 32'h80200003);
        r    = s << 1;
        if (ones % 2 == 0) r = r | 32'd1;
        return r;
    endfunction

    // Behavioural model of the main instance
    logic [31:0] m_rn;
    logic        m_fire;
    int          m_ec, m_lc;

    task automatic model_clock(input logic r, input logic ld, input logic en,
                               input logic clr, input logic [31:0] seed,
                               input logic [15:0] thr);
        logic fire_n;
        logic inc_l;
        fire_n = 1'b0;
        inc_l  = 1'b0;
        if (r) begin
            m_rn = 32'd0; m_fire = 1'b0; m_ec = 0; m_lc = 0;
        end else begin
            if (ld) begin
                m_rn = seed;
            end else if (en) begin
                if (m_rn == 32'hFFFF_FFFF) begin
                    m_rn  = 32'd0;
                    inc_l = 1'b1;
                end else begin
                    m_rn   = ref_shift(m_rn);
                    fire_n = ((m_rn % 32'd65536) < {16'd0, thr});
                end
            end
            if (clr) begin
                m_ec = 0; m_lc = 0;
            end else begin
                if (fire_n && m_ec < 65535) m_ec++;
                if (inc_l && m_lc < 65535) m_lc++;
            end
            m_fire = fire_n;
        end
    endtask

    typedef struct {
        logic        rst, load, en, clr;
        logic [31:0] seed;
        logic [15:0] thr;
        logic [31:0] rn;
        logic        fire;
        logic [15:0] ec;
        logic        lk;
        logic [15:0] lc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ld, input logic en, input logic clr,
                                input logic [31:0] seed, input logic [15:0] thr,
                                input logic [31:0] rn, input logic fire, input logic [15:0] ec,
                                input logic lk, input logic [15:0] lc);
        vec_t v;
        v.rst = r; v.load = ld; v.en = en; v.clr = clr; v.seed = seed; v.thr = thr;
        v.rn = rn; v.fire = fire; v.ec = ec; v.lk = lk; v.lc = lc;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1; clk_en = 1'b0; load = 1'b0; cnt_clr = 1'b0;
        seed_in = 32'd0; threshold = 16'd2;
        rst2 = 1'b1; en2 = 1'b0; load2 = 1'b0; clr2 = 1'b0; seed2 = 32'd0; thr2 = 16'd10;

        //            rst   load  en    clr   seed           thr      | rn            fire  ec     lk    lc
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,         16'd2, 32'd0,         1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd1,         1'b1, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd2, 32'd1,         1'b0, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd2,         1'b0, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd4,         1'b0, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd9,         1'b0, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF,  16'd2, 32'hFFFFFFFF,  1'b0, 16'd1, 1'b1, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd0,         1'b0, 16'd1, 1'b0, 16'd1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h12345678,  16'd2, 32'h12345678,  1'b0, 16'd1, 1'b0, 16'd1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0,         16'd2, 32'h12345678,  1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         16'd2, 32'd0,         1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'd0,         16'd2, 32'd1,         1'b1, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd2,         1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         16'd2, 32'd0,         1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,         16'd2, 32'd1,         1'b1, 16'd1, 1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h000000AA,  16'd2, 32'd0,         1'b0, 16'd0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF,  16'd2, 32'hFFFFFFFF,  1'b0, 16'd0, 1'b1, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd2, 32'hFFFFFFFF,  1'b0, 16'd0, 1'b1, 16'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'd0,         16'd2, 32'd0,         1'b0, 16'd0, 1'b0, 16'd0));

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; load = tbl[i].load; clk_en = tbl[i].en; cnt_clr = tbl[i].clr;
            seed_in = tbl[i].seed; threshold = tbl[i].thr;
            @(posedge clk); #1;
            check($sformatf("vec%0d.random_number", i), 64'(random_number), 64'(tbl[i].rn));
            check($sformatf("vec%0d.err_fire", i),      64'(err_fire),      64'(tbl[i].fire));
            check($sformatf("vec%0d.err_count", i),     64'(err_count),     64'(tbl[i].ec));
            check($sformatf("vec%0d.lockup", i),        64'(lockup),        64'(tbl[i].lk));
            check($sformatf("vec%0d.lockup_count", i),  64'(lockup_count),  64'(tbl[i].lc));
        end

        // Threshold zero: 1000 steps never fire
        rst = 1'b1; load = 1'b0; clk_en = 1'b0; cnt_clr = 1'b0; threshold = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0; clk_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (err_fire !== 1'b0) check("thr0.err_fire", 64'(err_fire), 64'd0);
        end
        check("thr0.err_count", 64'(err_count), 64'd0);
        clk_en = 1'b0;

        // Randomized stimulus against the reference model
        m_rn = 32'd0; m_fire = 1'b0; m_ec = 0; m_lc = 0;
        for (int i = 0; i < 3000; i++) begin
            rst     = (i == 0) || ($urandom_range(0, 99) == 0);
            load    = ($urandom_range(0, 15) == 0);
            seed_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            clk_en  = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: threshold = 16'd0;
                1: threshold = 16'hFFFF;
                2: threshold = 16'($urandom);
                default: threshold = 16'($urandom_range(0, 255));
            endcase
            model_clock(rst, load, clk_en, cnt_clr, seed_in, threshold);
            @(posedge clk); #1;
            check("rnd.random_number", 64'(random_number), 64'(m_rn));
            check("rnd.err_fire",      64'(err_fire),      64'(m_fire));
            check("rnd.err_count",     64'(err_count),     64'(m_ec));
            check("rnd.lockup",        64'(lockup),        64'(m_rn == 32'hFFFF_FFFF));
            check("rnd.lockup_count",  64'(lockup_count),  64'(m_lc));
        end
        rst = 1'b0; load = 1'b0; clk_en = 1'b0; cnt_clr = 1'b0;

        // STEPS=4 instance: one enable equals four single steps, two equal eight
        begin
            logic [31:0] s;
            rst2 = 1'b1; en2 = 1'b0; thr2 = 16'd10;
            @(posedge clk); #1;
            rst2 = 1'b0; en2 = 1'b1;
            @(posedge clk); #1;
            check("steps4.first", 64'(rn4), 64'h9);
            check("steps4.first_fire", 64'(fire4), 64'd1);
            check("steps4.first_count", 64'(ec4), 64'd1);
            @(posedge clk); #1;
            s = 32'd0;
            for (int k = 0; k < 8; k++) s = ref_shift(s);
            check("steps4.second", 64'(rn4), 64'(s));
            check("steps4.second_fire", 64'(fire4), 64'((s % 32'd65536) < 32'd10));
            check("steps4.lockup", 64'(lk4), 64'd0);
            check("steps4.lockup_count", 64'(lc4), 64'd0);
        end

        // Narrow counter saturates, then a clear coincident with a fire wins
        begin
            logic [31:0] s;
            int          fired;
            rst2 = 1'b1; en2 = 1'b0; thr2 = 16'hFFFF;
            @(posedge clk); #1;
            rst2 = 1'b0; en2 = 1'b1;
            s = 32'd0; fired = 0;
            for (int k = 0; k < 40; k++) begin
                s = ref_shift(s);
                if ((s % 32'd65536) != 32'd65535) fired++;
                @(posedge clk); #1;
            end
            check("sat.random_number", 64'(rns), 64'(s));
            check("sat.err_count_max", 64'(ecs), 64'((fired > 15) ? 15 : fired));
            check("sat.holds_15", 64'(ecs), 64'd15);
            check("sat.lockup", 64'(lks), 64'd0);
            check("sat.lockup_count", 64'(lcs), 64'd0);
            clr2 = 1'b1;
            s = ref_shift(s);
            @(posedge clk); #1;
            clr2 = 1'b0;
            check("sat.clr_fire", 64'(fires), 64'((s % 32'd65536) != 32'd65535));
            check("sat.clr_wins", 64'(ecs), 64'd0);
            en2 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_err_inject_gen.md
Name: lfsr_err_inject_gen

Overview:
Parametrised XNOR-Fibonacci LFSR pseudo-random source for the error-insertion datapath. It has the following features:
- configurable width and taps
- multiple shifts per enable
- runtime seed load
- lock-up detection and recovery
- threshold comparator that emits a per-step error-fire pulse, with a saturating count of fired errors

It drives error-insertion muxes downstream. Default configuration reproduces the team's existing 32-bit generator sequence (taps 31, 21, 1, 0).

Parameters:
WIDTH, 32, LFSR state width (>= 8).
TAPS, 32'h80200003, tap mask of WIDTH bits; bit i set = state[i] feeds the XNOR.
STEPS, 1, LFSR shifts applied per enabled clock (1..WIDTH).
THRESH_W, 16, comparator width (<= WIDTH).
CNT_W, 16, width of the error and lock-up counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
clk_en  in  1  step enable; advances LFSR by STEPS shifts
load  in  1  load seed_in into the state (priority over clk_en)
seed_in  in  WIDTH  seed value
threshold  in  THRESH_W  error probability threshold (fire when low bits < threshold)
cnt_clr  in  1  synchronous clear of err_count and lockup_count
random_number  out  WIDTH  current LFSR state (registered)
err_fire  out  1  one-cycle pulse; error to be inserted this cycle
err_count  out  CNT_W  saturating count of err_fire pulses
lockup  out  1  combinational; high while random_number is all-ones
lockup_count  out  CNT_W  saturating count of lock-up recoveries

Behaviour:
- Reset is synchronous and active-high on clk; there is one clock domain only.
- Reset values:
  - random_number = 0
  - err_fire = 0
  - err_count = 0
  - lockup_count = 0
- Reset overrides all other inputs, including mid-operation.
- Single shift: fb = ~^(s & TAPS); s_next = {s[WIDTH-2:0], fb}.
- Enabled step: STEPS single shifts are chained combinationally within one cycle. Latency is 1 clock from clk_en to the new random_number.
- Lock-up: the all-ones state is the XNOR lock-up state.
  - lockup is high while random_number is all-ones.
  - On clk_en with lockup high (and load low): state goes to 0 instead of shifting, and lockup_count increments.
  - err_fire = 0 on that recovery cycle.
- Priority per clock edge: rst > load > clk_en > hold.
- load:
  - random_number <= seed_in on the next edge.
  - err_fire <= 0.
  - An all-ones seed is accepted and raises lockup.
- Normal step (clk_en, no load, no lockup): err_fire <= (s_new[THRESH_W-1:0] < threshold), registered on the same edge as the state update.
  - err_fire is therefore valid in the same cycle as the new random_number.
- err_fire is 0 on every cycle that does not follow a normal step.
- threshold behaviour:
  - threshold = 0 never fires.
  - threshold = all-ones fires unless the low bits are all-ones.
- Counters:
  - err_count increments on each err_fire assertion.
  - Counters saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr zeroes both counters. When cnt_clr coincides with an increment, cnt_clr wins (result 0).
  - cnt_clr does not affect the LFSR state.
- Arithmetic is unsigned throughout.
- Parameter checks: elaboration error if STEPS is outside 1..WIDTH, THRESH_W > WIDTH, or TAPS is 0.

Test Plan:
- Defaults (WIDTH=32, STEPS=1):
  - Stimulus: reset, then 4 clk_en pulses.
  - Required: random_number = 0x00000001, 0x00000002, 0x00000004, 0x00000009 after each step; lockup stays 0.
- STEPS=4 instance:
  - Stimulus: reset, then one clk_en.
  - Required: random_number = 0x00000009 after 1 clock; 2 clk_en give the same value as the STEPS=1 instance after 8 steps.
- Threshold = 2, THRESH_W=16:
  - Stimulus: reset, then 4 steps.
  - Required: err_fire = 1, 0, 0, 0 with err_count = 1.
- Threshold = 0:
  - Stimulus: 1000 steps.
  - Required: err_fire never asserts; err_count = 0.
- Lock-up:
  - Stimulus: load with seed_in = 0xFFFFFFFF, then clk_en.
  - Required: after the load, lockup = 1 and err_fire = 0; after clk_en, random_number = 0, lockup = 0, lockup_count = 1.
- Simultaneous events:
  - load and clk_en together: seed loaded, no shift, err_fire = 0.
  - rst asserted mid-run: all outputs return to reset values on the next edge.
  - err_count at max plus a further fire: holds max.
  - cnt_clr together with err_fire: err_count = 0.
